// File: rtl/arp_pkg.sv
// arp_pkg: constants and types shared by the ARP receive parser and transmitter
package arp_pkg;
    localparam int          ARP_LENGTH    = 28;
    localparam logic [15:0] HTYPE         = 16'h0001;
    localparam logic [15:0] PTYPE         = 16'h0800;
    localparam logic [7:0]  HLEN          = 8'd6;
    localparam logic [7:0]  PLEN          = 8'd4;
    localparam logic [7:0]  OPER_REQUEST  = 8'd1;
    localparam logic [7:0]  OPER_REPLY    = 8'd2;
    localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
    localparam int          SHA_OFFSET    = 8;
    localparam int          SPA_OFFSET    = 14;
    localparam int          THA_OFFSET    = 18;
    localparam int          TPA_OFFSET    = 24;

    typedef enum logic [1:0] {IDLE, SEND, ACK} arp_state_t;
endpackage

// File: rtl/arp_send.sv
// arp_send: serialises a 28-byte ARP reply or request payload onto a byte-wide AXI-Stream
module arp_send
    import arp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] local_ip_addr,
    input  logic [47:0] local_mac_addr,
    input  logic        reply_req_in,
    input  logic [31:0] remote_ip_addr_in,
    input  logic [47:0] remote_mac_addr_in,
    output logic        arp_reply_ack,
    output logic        reply_ready_out,
    input  logic        req_start_in,
    input  logic [31:0] req_target_ip_in,
    output logic        req_done_out,
    output logic [7:0]  arp_tdata_out,
    output logic        arp_tvalid_out,
    output logic        arp_tlast_out,
    input  logic        arp_tready_in
);
    arp_state_t   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [7:0]   oper_q, oper_d;
    logic [47:0]  sha_q, sha_d, tha_q, tha_d;
    logic [31:0]  spa_q, spa_d, tpa_q, tpa_d;
    logic         done_q, done_d;
    logic         last;
    logic [4:0]   sel;
    logic [255:0] pkt;

    // Whole payload laid out first-byte-most-significant; padded to 32 bytes so any counter value indexes in range
    assign pkt  = {HTYPE, PTYPE, HLEN, PLEN, 8'h00, oper_q, sha_q, spa_q, tha_q, tpa_q, 32'h0};
    assign sel  = 5'(31) - cnt_q;
    assign last = cnt_q == 5'(ARP_LENGTH - 1);

    assign arp_tvalid_out  = state_q == SEND;
    assign arp_tlast_out   = state_q == SEND && last;
    assign arp_tdata_out   = pkt[{sel, 3'b000} +: 8];
    assign arp_reply_ack   = state_q == ACK;
    assign reply_ready_out = state_q == IDLE;
    assign req_done_out    = done_q;

    // Next-state: capture addresses in IDLE, step the byte counter on each handshake, hold ACK until the requester lets go
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oper_d  = oper_q;
        sha_d   = sha_q;
        spa_d   = spa_q;
        tha_d   = tha_q;
        tpa_d   = tpa_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (reply_req_in || req_start_in) begin
                    state_d = SEND;
                    sha_d   = local_mac_addr;
                    spa_d   = local_ip_addr;
                    oper_d  = reply_req_in ? OPER_REPLY : OPER_REQUEST;
                    tha_d   = reply_req_in ? remote_mac_addr_in : 48'h0;
                    tpa_d   = reply_req_in ? remote_ip_addr_in : req_target_ip_in;
                end
            end
            SEND: begin
                if (arp_tready_in) begin
                    cnt_d = last ? 5'd0 : cnt_q + 5'd1;
                    if (last) begin
                        state_d = oper_q == OPER_REPLY ? ACK : IDLE;
                        done_d  = oper_q == OPER_REQUEST;
                    end
                end
            end
            ACK:     state_d = reply_req_in ? ACK : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and captured packet fields
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            oper_q  <= '0;
            sha_q   <= '0;
            spa_q   <= '0;
            tha_q   <= '0;
            tpa_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oper_q  <= oper_d;
            sha_q   <= sha_d;
            spa_q   <= spa_d;
            tha_q   <= tha_d;
            tpa_q   <= tpa_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_arp_send.sv
// tb_arp_send: randomized self-checking bench for arp_send against a byte-list model of the ARP payload
module tb_arp_send;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] local_ip_addr = '0;
    logic [47:0] local_mac_addr = '0;
    logic        reply_req_in = 1'b0;
    logic [31:0] remote_ip_addr_in = '0;
    logic [47:0] remote_mac_addr_in = '0;
    logic        arp_reply_ack;
    logic        reply_ready_out;
    logic        req_start_in = 1'b0;
    logic [31:0] req_target_ip_in = '0;
    logic        req_done_out;
    logic [7:0]  arp_tdata_out;
    logic        arp_tvalid_out;
    logic        arp_tlast_out;
    logic        arp_tready_in = 1'b0;

    int total = 0;
    int bad = 0;
    logic [7:0] got[$];
    logic [7:0] exp[$];
    int stab, done_n, ack_n, tlast_n, tlast_idx, btb;
    bit to;

    arp_send dut (
        .clk(clk), .reset(reset),
        .local_ip_addr(local_ip_addr), .local_mac_addr(local_mac_addr),
        .reply_req_in(reply_req_in), .remote_ip_addr_in(remote_ip_addr_in),
        .remote_mac_addr_in(remote_mac_addr_in), .arp_reply_ack(arp_reply_ack),
        .reply_ready_out(reply_ready_out), .req_start_in(req_start_in),
        .req_target_ip_in(req_target_ip_in), .req_done_out(req_done_out),
        .arp_tdata_out(arp_tdata_out), .arp_tvalid_out(arp_tvalid_out),
        .arp_tlast_out(arp_tlast_out), .arp_tready_in(arp_tready_in)
    );

    always #5 clk = ~clk;

    // Reference: the ARP payload as an ordered byte list built from its fields
    function automatic void model(input bit rep, input logic [47:0] sha, input logic [31:0] spa,
                                  input logic [47:0] tha, input logic [31:0] tpa);
        exp = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, rep ? 8'h02 : 8'h01};
        for (int i = 5; i >= 0; i--) exp.push_back(sha[8*i +: 8]);
        for (int i = 3; i >= 0; i--) exp.push_back(spa[8*i +: 8]);
        for (int i = 5; i >= 0; i--) exp.push_back(tha[8*i +: 8]);
        for (int i = 3; i >= 0; i--) exp.push_back(tpa[8*i +: 8]);
    endfunction

    // Stream sink: random tready, optional 5-cycle stall at hold_at, optional input disturbance at change_at
    task automatic collect(input int pct, input int hold_at, input int change_at);
        int hold = 0, post = 0;
        bit hold_done = 0, changed = 0, prev_stall = 0, last_hs = 0, pl = 0;
        logic [7:0] pd = '0;
        got.delete();
        stab = 0; done_n = 0; ack_n = 0; tlast_n = 0; tlast_idx = -1; btb = 0; to = 1;
        for (int c = 0; c < 1000; c++) begin
            req_start_in = 1'b0;
            if (hold_at >= 0 && !hold_done && got.size() == hold_at) begin
                hold = 5;
                hold_done = 1;
            end
            if (hold > 0) begin
                arp_tready_in = 1'b0;
                hold--;
            end else arp_tready_in = $urandom_range(99) < pct;
            if (change_at >= 0 && !changed && got.size() == change_at) begin
                changed = 1;
                remote_ip_addr_in = $urandom();
                req_target_ip_in = $urandom();
                req_start_in = 1'b1;
            end
            #1;
            if (req_done_out) done_n++;
            if (arp_reply_ack) ack_n++;
            if (last_hs && arp_tvalid_out) btb++;
            last_hs = 0;
            if (prev_stall && arp_tvalid_out && (arp_tdata_out !== pd || arp_tlast_out !== pl)) stab++;
            prev_stall = arp_tvalid_out && !arp_tready_in;
            pd = arp_tdata_out;
            pl = arp_tlast_out;
            if (arp_tvalid_out && arp_tready_in) begin
                got.push_back(arp_tdata_out);
                if (arp_tlast_out) begin
                    tlast_n++;
                    tlast_idx = got.size() - 1;
                    last_hs = 1;
                end
            end
            if (tlast_n > 0) post++;
            @(negedge clk);
            if (post >= 3) begin
                to = 0;
                break;
            end
        end
        req_start_in = 1'b0;
    endtask

    task automatic drop_reply();
        reply_req_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        arp_tready_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (arp_tvalid_out !== 1'b0) begin bad++; $display("FAIL reset_tvalid got %b exp 0", arp_tvalid_out); end
        total++; if (arp_tlast_out !== 1'b0) begin bad++; $display("FAIL reset_tlast got %b exp 0", arp_tlast_out); end
        total++; if (arp_tdata_out !== 8'h00) begin bad++; $display("FAIL reset_tdata got %h exp 00", arp_tdata_out); end
        total++; if (arp_reply_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got %b exp 0", arp_reply_ack); end
        total++; if (req_done_out !== 1'b0) begin bad++; $display("FAIL reset_done got %b exp 0", req_done_out); end
        total++; if (reply_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got %b exp 1", reply_ready_out); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reply();
        @(negedge clk);
        local_ip_addr = 32'hc0a8010a;
        local_mac_addr = 48'h000a35010203;
        remote_ip_addr_in = 32'hc0a80114;
        remote_mac_addr_in = 48'h112233445566;
        reply_req_in = 1'b1;
        @(negedge clk);
        collect(100, -1, -1);
        exp = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02, 8'h00, 8'h0a, 8'h35, 8'h01, 8'h02, 8'h03,
                8'hc0, 8'ha8, 8'h01, 8'h0a, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hc0, 8'ha8, 8'h01, 8'h14};
        total++; if (to) begin bad++; $display("FAIL reply_timeout no tlast within bound"); end
        total++; if (got.size() != 28) begin bad++; $display("FAIL reply_len got %0d exp 28", got.size()); end
        for (int i = 0; i < 28 && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL reply_byte[%0d] got %h exp %h", i, got[i], exp[i]); end
        end
        total++; if (tlast_idx != 27 || tlast_n != 1) begin bad++; $display("FAIL reply_tlast idx %0d count %0d exp 27/1", tlast_idx, tlast_n); end
        total++; if (done_n != 0) begin bad++; $display("FAIL reply_done pulses %0d exp 0", done_n); end
        repeat (3) @(negedge clk);
        #1;
        total++; if (arp_reply_ack !== 1'b1) begin bad++; $display("FAIL reply_ack_held got %b exp 1", arp_reply_ack); end
        total++; if (reply_ready_out !== 1'b0) begin bad++; $display("FAIL reply_ready_in_ack got %b exp 0", reply_ready_out); end
        reply_req_in = 1'b0;
        @(negedge clk);
        #1;
        total++; if (arp_reply_ack !== 1'b0) begin bad++; $display("FAIL reply_ack_drop got %b exp 0", arp_reply_ack); end
        total++; if (reply_ready_out !== 1'b1) begin bad++; $display("FAIL reply_idle_ready got %b exp 1", reply_ready_out); end
        @(negedge clk);
    endtask

    task automatic test_request();
        @(negedge clk);
        req_target_ip_in = 32'h0a000001;
        req_start_in = 1'b1;
        @(negedge clk);
        req_start_in = 1'b0;
        collect(100, -1, -1);
        model(0, 48'h000a35010203, 32'hc0a8010a, 48'h0, 32'h0a000001);
        total++; if (to) begin bad++; $display("FAIL request_timeout no tlast within bound"); end
        total++; if (got.size() != 28) begin bad++; $display("FAIL request_len got %0d exp 28", got.size()); end
        for (int i = 0; i < 28 && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL request_byte[%0d] got %h exp %h", i, got[i], exp[i]); end
        end
        total++; if (done_n != 1) begin bad++; $display("FAIL request_done pulses %0d exp 1", done_n); end
        total++; if (ack_n != 0) begin bad++; $display("FAIL request_ack cycles %0d exp 0", ack_n); end
        #1;
        total++; if (reply_ready_out !== 1'b1 || arp_tvalid_out !== 1'b0) begin bad++; $display("FAIL request_idle ready %b tvalid %b exp 1/0", reply_ready_out, arp_tvalid_out); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [47:0] rm;
        logic [31:0] ri;
        @(negedge clk);
        rm = {$urandom(), $urandom()};
        ri = $urandom();
        remote_mac_addr_in = rm;
        remote_ip_addr_in = ri;
        reply_req_in = 1'b1;
        @(negedge clk);
        collect(50, 12, -1);
        model(1, local_mac_addr, local_ip_addr, rm, ri);
        total++; if (to) begin bad++; $display("FAIL bp_timeout no tlast within bound"); end
        total++; if (got.size() != 28) begin bad++; $display("FAIL bp_handshakes got %0d exp 28", got.size()); end
        for (int i = 0; i < 28 && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL bp_byte[%0d] got %h exp %h", i, got[i], exp[i]); end
        end
        total++; if (stab != 0) begin bad++; $display("FAIL bp_stable changes-while-stalled %0d exp 0", stab); end
        total++; if (btb != 0) begin bad++; $display("FAIL bp_gap tvalid-after-tlast %0d exp 0", btb); end
        drop_reply();
    endtask

    task automatic test_simultaneous();
        logic [47:0] rm;
        logic [31:0] ri;
        @(negedge clk);
        rm = {$urandom(), $urandom()};
        ri = $urandom();
        remote_mac_addr_in = rm;
        remote_ip_addr_in = ri;
        req_target_ip_in = $urandom();
        reply_req_in = 1'b1;
        req_start_in = 1'b1;
        @(negedge clk);
        req_start_in = 1'b0;
        collect(100, -1, -1);
        model(1, local_mac_addr, local_ip_addr, rm, ri);
        total++; if (to || got.size() != 28) begin bad++; $display("FAIL simul_len got %0d exp 28 timeout %0b", got.size(), to); end
        for (int i = 0; i < 28 && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL simul_byte[%0d] got %h exp %h", i, got[i], exp[i]); end
        end
        total++; if (done_n != 0) begin bad++; $display("FAIL simul_done pulses %0d exp 0", done_n); end
        drop_reply();
        #1;
        total++; if (arp_tvalid_out !== 1'b0) begin bad++; $display("FAIL simul_no_request got tvalid %b exp 0", arp_tvalid_out); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit reached = 0;
        logic [47:0] rm;
        logic [31:0] ri;
        @(negedge clk);
        reply_req_in = 1'b1;
        arp_tready_in = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 100; c++) begin
            #1;
            if (n == 15) begin
                reached = 1;
                break;
            end
            if (arp_tvalid_out && arp_tready_in) n++;
            @(negedge clk);
        end
        total++; if (!reached) begin bad++; $display("FAIL rstmid_reach handshakes %0d exp 15", n); end
        reset = 1'b1;
        reply_req_in = 1'b0;
        @(negedge clk);
        #1;
        total++; if (arp_tvalid_out !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid got %b exp 0", arp_tvalid_out); end
        total++; if (arp_tlast_out !== 1'b0) begin bad++; $display("FAIL rstmid_tlast got %b exp 0", arp_tlast_out); end
        total++; if (reply_ready_out !== 1'b1) begin bad++; $display("FAIL rstmid_ready got %b exp 1", reply_ready_out); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rm = {$urandom(), $urandom()};
        ri = $urandom();
        remote_mac_addr_in = rm;
        remote_ip_addr_in = ri;
        reply_req_in = 1'b1;
        @(negedge clk);
        collect(100, -1, -1);
        model(1, local_mac_addr, local_ip_addr, rm, ri);
        total++; if (to || got.size() != 28) begin bad++; $display("FAIL rstmid_len got %0d exp 28 timeout %0b", got.size(), to); end
        for (int i = 0; i < 28 && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL rstmid_byte[%0d] got %h exp %h", i, got[i], exp[i]); end
        end
        drop_reply();
    endtask

    task automatic test_addr_change();
        logic [47:0] rm;
        logic [31:0] ri;
        bit extra = 0;
        @(negedge clk);
        rm = {$urandom(), $urandom()};
        ri = $urandom();
        remote_mac_addr_in = rm;
        remote_ip_addr_in = ri;
        reply_req_in = 1'b1;
        @(negedge clk);
        collect(100, -1, 5);
        model(1, local_mac_addr, local_ip_addr, rm, ri);
        total++; if (to || got.size() != 28) begin bad++; $display("FAIL chg_len got %0d exp 28 timeout %0b", got.size(), to); end
        for (int i = 0; i < 28 && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL chg_byte[%0d] got %h exp %h", i, got[i], exp[i]); end
        end
        total++; if (done_n != 0) begin bad++; $display("FAIL chg_done pulses %0d exp 0", done_n); end
        drop_reply();
        repeat (4) begin
            #1;
            if (arp_tvalid_out) extra = 1;
            @(negedge clk);
        end
        total++; if (extra) begin bad++; $display("FAIL chg_dropped_request got tvalid 1 exp 0"); end
    endtask

    task automatic test_random();
        bit rep;
        logic [47:0] rm;
        logic [31:0] ri, ti;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rep = $urandom_range(1);
            rm = {$urandom(), $urandom()};
            ri = $urandom();
            ti = $urandom();
            local_mac_addr = {$urandom(), $urandom()};
            local_ip_addr = $urandom();
            remote_mac_addr_in = rm;
            remote_ip_addr_in = ri;
            req_target_ip_in = ti;
            reply_req_in = rep;
            req_start_in = !rep;
            @(negedge clk);
            req_start_in = 1'b0;
            collect($urandom_range(100, 30), -1, -1);
            model(rep, local_mac_addr, local_ip_addr, rep ? rm : 48'h0, rep ? ri : ti);
            total++; if (to || got.size() != 28) begin bad++; $display("FAIL rand%0d_len got %0d exp 28 timeout %0b", k, got.size(), to); end
            for (int i = 0; i < 28 && i < got.size(); i++) begin
                total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL rand%0d_byte[%0d] got %h exp %h", k, i, got[i], exp[i]); end
            end
            total++; if (done_n != (rep ? 0 : 1)) begin bad++; $display("FAIL rand%0d_done pulses %0d exp %0d", k, done_n, rep ? 0 : 1); end
            total++; if (stab != 0) begin bad++; $display("FAIL rand%0d_stable changes %0d exp 0", k, stab); end
            if (rep) drop_reply();
        end
    endtask

    initial begin
        test_reset();
        test_reply();
        test_request();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_addr_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
